regfile_sb: RTL and testbench

//   Parametrised integer register file for the RISC-V core: 2 read ports, 1 write port, x0 hardwired to 0.

---
 rtl/regfile_sb.sv | 104 ++++++++++
 tb/tb_regfile_sb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file (2R/1W, x0 hardwired to zero) with optional write-to-read
// bypass and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic            busy_any
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend_reg;
  logic [NREG-1:0] pend_next;
  logic            wr_en;
  logic            rsv_ok;
  logic            release_ok;

  // Gating with rst_n keeps the bypass path from leaking wdata while in reset.
  assign wr_en      = we && (waddr != '0) && rst_n;
  assign rsv_ok     = rsv_en && (rsv_addr != '0);
  assign release_ok = wr_en && !(rsv_ok && (rsv_addr == waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Reserve is applied after release so it wins on a same-register collision.
  always_comb begin
    pend_next = pend_reg;
    if (flush) begin
      pend_next = '0;
    end else begin
      if (wr_en && pend_reg[waddr]) begin
        pend_next[waddr] = 1'b0;
      end
      if (rsv_ok) begin
        pend_next[rsv_addr] = 1'b1;
      end
    end
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  assign busy_any = |pend_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            bz;

    assign ra = (gi == 0) ? raddr1 : raddr2;

    always_comb begin
      rd = regs[ra];
      bz = pend_reg[ra];
      if (BYPASS != 0) begin
        if (wr_en && (waddr == ra)) begin
          rd = wdata;
        end
        if (flush || (release_ok && (waddr == ra))) begin
          bz = 1'b0;
        end
      end
      if (ra == '0) begin
        rd = '0;
        bz = 1'b0;
      end
    end
  end

  assign rdata1 = g_rd[0].rd;
  assign rdata2 = g_rd[1].rd;
  assign busy1  = g_rd[0].bz;
  assign busy2  = g_rd[1].bz;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (BYPASS=1): inputs change on the falling edge,
// outputs are sampled 1 ns later, state updates on the following rising edge.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic        busy1;
  logic        busy2;
  logic        busy_any;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy1(busy1), .busy2(busy2), .busy_any(busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  // Advance to the next falling edge with all strobes idle.
  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    waddr = 5'd0; wdata = '0; rsv_addr = 5'd0;
    #1;
    for (int a = 0; a < 32; a += 2) begin
      raddr1 = 5'(a); raddr2 = 5'(a + 1);
      #1;
      total++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0 || busy_any !== 1'b0) begin
        bad++;
        $display("FAIL reset_read a=%0d rdata1=%h rdata2=%h busy=%b%b%b want all 0", a, rdata1, rdata2, busy1, busy2, busy_any);
      end
    end
    // A write attempted while in reset must not appear through the bypass.
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr1 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_bypass rdata1=%h want=0", rdata1); end
    @(negedge clk); idle(); rst_n = 1'b1;
    step();
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD; raddr1 = 5'd0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin bad++; $display("FAIL x0_write_cycle rdata1=%h want=0", rdata1); end
    step();
    #1;
    total++;
    if (rdata1 !== 32'h0) begin bad++; $display("FAIL x0_read rdata1=%h want=0", rdata1); end
    $display("txn reset/x0 done");
  endtask

  task automatic test_write_read();
    step();
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_000D; raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    total++;
    if (rdata1 !== 32'hD) begin bad++; $display("FAIL wr_bypass rdata1=%h want=%h", rdata1, 32'hD); end
    total++;
    if (rdata2 !== 32'h0) begin bad++; $display("FAIL wr_other rdata2=%h want=0", rdata2); end
    step();
    raddr2 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 32'hD || rdata2 !== 32'hD) begin
      bad++; $display("FAIL wr_read rdata1=%h rdata2=%h want=%h", rdata1, rdata2, 32'hD);
    end
    $display("txn write x5=0xD read back");
  endtask

  task automatic test_scoreboard();
    step();
    rsv_en = 1'b1; rsv_addr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL rsv_same_cycle busy1=%b want=0", busy1); end
    step();
    #1;
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || busy_any !== 1'b1) begin
      bad++; $display("FAIL rsv_busy busy1=%b busy2=%b busy_any=%b want 111", busy1, busy2, busy_any);
    end
    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'h8;
    #1;
    total++;
    if (busy1 !== 1'b0 || rdata1 !== 32'h8) begin
      bad++; $display("FAIL release_bypass busy1=%b rdata1=%h want 0/%h", busy1, rdata1, 32'h8);
    end
    step();
    #1;
    total++;
    if (busy1 !== 1'b0 || busy_any !== 1'b0 || rdata1 !== 32'h8) begin
      bad++; $display("FAIL released busy1=%b busy_any=%b rdata1=%h want 0/0/%h", busy1, busy_any, rdata1, 32'h8);
    end
    // Reserving x0 is ignored.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    #1;
    total++;
    if (busy_any !== 1'b0) begin bad++; $display("FAIL rsv_x0 busy_any=%b want=0", busy_any); end
    $display("txn reserve/release x7");
  endtask

  task automatic test_write_and_reserve();
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3; raddr1 = 5'd3;
    step();
    we = 1'b1; waddr = 5'd3; wdata = 32'h33; rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    total++;
    if (busy1 !== 1'b1 || rdata1 !== 32'h33) begin
      bad++; $display("FAIL wr_rsv_cycle busy1=%b rdata1=%h want 1/%h", busy1, rdata1, 32'h33);
    end
    step();
    #1;
    total++;
    if (busy1 !== 1'b1 || rdata1 !== 32'h33) begin
      bad++; $display("FAIL wr_rsv_after busy1=%b rdata1=%h want 1/%h", busy1, rdata1, 32'h33);
    end
    we = 1'b1; waddr = 5'd3; wdata = 32'h34;
    step();
    #1;
    total++;
    if (busy_any !== 1'b0 || rdata1 !== 32'h34) begin
      bad++; $display("FAIL wr_rsv_release busy_any=%b rdata1=%h want 0/%h", busy_any, rdata1, 32'h34);
    end
    $display("txn write+reserve x3");
  endtask

  task automatic test_flush();
    logic [31:0] vals [3];
    logic [4:0]  adrs [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h44;
    adrs[0] = 5'd1;   adrs[1] = 5'd2;   adrs[2] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      we = 1'b1; waddr = adrs[i]; wdata = vals[i];
      step();
      rsv_en = 1'b1; rsv_addr = adrs[i];
    end
    step();
    raddr1 = 5'd1; raddr2 = 5'd4;
    #1;
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || busy_any !== 1'b1) begin
      bad++; $display("FAIL pre_flush busy1=%b busy2=%b busy_any=%b want 111", busy1, busy2, busy_any);
    end
    flush = 1'b1;
    #1;
    total++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL flush_cycle busy1=%b busy2=%b want 00", busy1, busy2);
    end
    step();
    #1;
    total++;
    if (busy_any !== 1'b0 || rdata1 !== 32'h11 || rdata2 !== 32'h44) begin
      bad++; $display("FAIL post_flush busy_any=%b rdata1=%h rdata2=%h want 0/11/44", busy_any, rdata1, rdata2);
    end
    raddr1 = 5'd2;
    #1;
    total++;
    if (rdata1 !== 32'h22) begin bad++; $display("FAIL flush_keep_x2 rdata1=%h want=22", rdata1); end
    step();
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9; raddr1 = 5'd9;
    step();
    #1;
    total++;
    if (busy1 !== 1'b0 || busy_any !== 1'b0) begin
      bad++; $display("FAIL flush_rsv busy1=%b busy_any=%b want 00", busy1, busy_any);
    end
    $display("txn flush");
  endtask

  task automatic test_back_to_back();
    step();
    we = 1'b1; waddr = 5'd10; wdata = 32'hA0A0_0001;
    @(negedge clk);
    waddr = 5'd11; wdata = 32'hB0B0_0002; raddr1 = 5'd10; raddr2 = 5'd11;
    #1;
    total++;
    if (rdata1 !== 32'hA0A0_0001 || rdata2 !== 32'hB0B0_0002) begin
      bad++; $display("FAIL b2b_cycle rdata1=%h rdata2=%h want a0a00001/b0b00002", rdata1, rdata2);
    end
    @(negedge clk);
    waddr = 5'd10; wdata = 32'hA0A0_0003;
    #1;
    total++;
    if (rdata1 !== 32'hA0A0_0003 || rdata2 !== 32'hB0B0_0002) begin
      bad++; $display("FAIL b2b_overwrite rdata1=%h rdata2=%h want a0a00003/b0b00002", rdata1, rdata2);
    end
    step();
    raddr2 = 5'd10;
    #1;
    total++;
    if (rdata1 !== 32'hA0A0_0003 || rdata2 !== 32'hA0A0_0003) begin
      bad++; $display("FAIL same_addr rdata1=%h rdata2=%h want a0a00003", rdata1, rdata2);
    end
    $display("txn back-to-back writes x10/x11");
  endtask

  task automatic test_async_reset();
    step();
    we = 1'b1; waddr = 5'd1; wdata = 32'h7;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd2;
    step();
    raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    total++;
    if (rdata1 !== 32'h7 || busy2 !== 1'b1) begin
      bad++; $display("FAIL pre_areset rdata1=%h busy2=%b want 7/1", rdata1, busy2);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h0 || busy2 !== 1'b0 || busy_any !== 1'b0) begin
      bad++; $display("FAIL areset rdata1=%h busy2=%b busy_any=%b want 0/0/0", rdata1, busy2, busy_any);
    end
    #1 rst_n = 1'b1;
    step();
    #1;
    total++;
    if (rdata1 !== 32'h0 || busy_any !== 1'b0) begin
      bad++; $display("FAIL post_areset rdata1=%h busy_any=%b want 0/0", rdata1, busy_any);
    end
    $display("txn async reset mid-cycle");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_write_and_reserve();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
